// File: rtl/des_ip_loader.sv
// DES input loader: assembles a 64-bit block from a byte stream, applies the
// Initial Permutation and double-buffers the L0/R0 halves for the round engine.
module des_ip_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_dec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] l0,
    output logic [31:0] r0,
    output logic        out_dec
);

    localparam int unsigned IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    logic [63:0] asm;
    logic [3:0]  cnt;
    logic        dec_cap;
    logic [63:0] ip_blk;
    logic        accept;
    logic        transfer;

    // DES bit n lives at vector bit 64-n; the table is a fixed rewire.
    always_comb begin
        ip_blk = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            ip_blk[6'(63 - k)] = asm[6'(64 - IP_TBL[k])];
        end
    end

    assign in_ready = (cnt < 4'd8);
    assign accept   = in_valid & in_ready;
    assign transfer = (cnt == 4'd8) & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            asm     <= '0;
            cnt     <= '0;
            dec_cap <= 1'b0;
        end else if (flush || transfer) begin
            // A complete block still transfers under flush; only cnt is cleared.
            cnt <= '0;
        end else if (accept) begin
            asm <= {asm[55:0], in_byte};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd0) begin
                dec_cap <= in_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l0        <= '0;
            r0        <= '0;
            out_dec   <= 1'b0;
            out_valid <= 1'b0;
        end else if (transfer) begin
            {l0, r0}  <= ip_blk;
            out_dec   <= dec_cap;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_des_ip_loader.sv
// Self-checking bench for des_ip_loader: transaction model with byte queue,
// table-driven IP reference and final-permutation round trip.
module tb_des_ip_loader;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_dec, out_ready;
    logic [7:0]  in_byte;
    logic        in_ready, out_valid, out_dec;
    logic [31:0] l0, r0;

    int errs = 0;
    int checks = 0;
    int delivered = 0;

    des_ip_loader dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_dec(in_dec),
        .out_valid(out_valid), .out_ready(out_ready),
        .l0(l0), .r0(r0), .out_dec(out_dec)
    );

    always #5 clk = ~clk;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    // out DES bit k takes in DES bit TBL[k]; DES bit n is vector bit 64-n
    function automatic logic [63:0] des_perm(input logic [63:0] x, input bit use_fp);
        logic [63:0] y = '0;
        for (int k = 1; k <= 64; k++) begin
            int src = use_fp ? FP_T[k-1] : IP_T[k-1];
            y[64-k] = x[64-src];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of accepted bytes plus the presented block.
    logic [7:0]  mq[$];
    logic        m_dec = 1'b0, m_full = 1'b0, m_odec = 1'b0;
    logic [63:0] m_out = '0, m_raw = '0;

    always @(negedge clk) begin
        logic        xfer;
        logic [63:0] blk;
        chk("in_ready", in_ready, mq.size() < 8);
        chk("out_valid", out_valid, m_full);
        chk("l0", l0, m_out[63:32]);
        chk("r0", r0, m_out[31:0]);
        chk("out_dec", out_dec, m_odec);
        if (m_full) chk("round_trip", des_perm({l0, r0}, 1'b1), m_raw);

        if (rst) begin
            mq.delete();
            m_dec = 0; m_full = 0; m_odec = 0; m_out = '0; m_raw = '0;
        end else begin
            xfer = (mq.size() == 8) && (!m_full || out_ready);
            if (m_full && out_ready) delivered++;
            if (xfer) begin
                blk = '0;
                for (int i = 0; i < 8; i++) blk = {blk[55:0], mq[i]};
                m_raw = blk; m_out = des_perm(blk, 1'b0); m_odec = m_dec; m_full = 1;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
            if (flush || xfer) begin
                mq.delete();
            end else if (in_valid && mq.size() < 8) begin
                if (mq.size() == 0) m_dec = in_dec;
                mq.push_back(in_byte);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic d);
        bit done = 0;
        int n = 0;
        in_valid = 1; in_byte = b; in_dec = d;
        while (!done) begin
            @(negedge clk); done = in_ready;
            @(posedge clk); #1;
            n++;
            if (!done && n > 60) begin
                chk("send_byte timeout", 0, 1);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic send_block(input logic [63:0] b, input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_byte(b[63-8*i -: 8], d[7-i]);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("wait_valid timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1; @(posedge clk); #1; out_ready = 0;
    endtask

    localparam logic [63:0] KV = 64'h0123456789ABCDEF;

    initial begin
        logic [63:0] b2, expb;
        int base;
        rst = 1; flush = 0; in_valid = 0; in_byte = 0; in_dec = 0; out_ready = 0;
        repeat (2) @(posedge clk); #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset l0", l0, 0);
        chk("reset in_ready", in_ready, 1);
        rst = 0;

        send_block(KV, 8'h00);
        chk("lat edge N out_valid", out_valid, 0);
        chk("lat edge N in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("lat edge N+1 out_valid", out_valid, 1);
        chk("kv l0", l0, 32'hCC00CCFF);
        chk("kv r0", r0, 32'hF0AAF0AA);
        chk("kv out_dec", out_dec, 0);

        b2 = {$urandom, $urandom};
        send_block(b2, 8'b1010_1010);
        chk("bp in_ready low", in_ready, 0);
        repeat (3) @(posedge clk); #1;
        chk("bp hold l0", l0, 32'hCC00CCFF);
        chk("bp hold r0", r0, 32'hF0AAF0AA);
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp no bubble", out_valid, 1);
        chk("bp block2", {l0, r0}, des_perm(b2, 1'b0));
        chk("bp out_dec", out_dec, 1);
        @(posedge clk); #1;
        chk("bp drained", out_valid, 0);
        out_ready = 0;

        for (int i = 0; i < 3; i++) send_byte(8'hEE, 1'b1);
        flush = 1; @(posedge clk); #1; flush = 0;
        send_block(KV, 8'h00);
        wait_valid();
        chk("flush3 l0", l0, 32'hCC00CCFF);
        chk("flush3 r0", r0, 32'hF0AAF0AA);
        drain();

        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        in_valid = 1; in_byte = 8'h5A; flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush+accept in_ready", in_ready, 1);
        send_block(KV, 8'h80);
        wait_valid();
        chk("flush+accept l0", l0, 32'hCC00CCFF);
        chk("flush+accept r0", r0, 32'hF0AAF0AA);
        chk("flush+accept dec", out_dec, 1);
        drain();

        for (int i = 0; i < 4; i++) send_byte(8'h99, 1'b1);
        rst = 1; @(posedge clk); #1; rst = 0;
        chk("rst mid in_ready", in_ready, 1);
        send_block(KV, 8'h00);
        wait_valid();
        chk("rst mid l0", l0, 32'hCC00CCFF);
        rst = 1; @(posedge clk); #1; rst = 0;
        chk("rst hold out_valid", out_valid, 0);
        chk("rst hold l0r0", {l0, r0}, 0);
        chk("rst hold in_ready", in_ready, 1);
        send_block(KV, 8'h00);
        wait_valid();
        chk("rst hold reload r0", r0, 32'hF0AAF0AA);
        drain();

        out_ready = 1;
        for (int i = 0; i < 64; i++) begin
            expb = '0;
            for (int k = 1; k <= 64; k++) if (IP_T[k-1] == 64 - i) expb[64-k] = 1'b1;
            send_block(64'd1 << i, 8'h00);
            wait_valid();
            chk("onehot count", $countones({l0, r0}), 1);
            chk("onehot pos", {l0, r0}, expb);
        end

        base = delivered;
        for (int c = 0; c < 40000 && delivered < base + 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            in_dec    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            @(posedge clk); #1;
        end
        if (delivered < base + 1000) chk("random delivered", delivered - base, 1000);
        in_valid = 0; flush = 0; rst = 0; out_ready = 1;
        repeat (3) @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/des_ip_loader.md
# des_ip_loader

Front-end loader of the DES datapath, sitting in the input direction of the round core. It assembles a 64-bit block from an 8-byte stream using a valid/ready handshake. It applies the DES Initial Permutation (IP), the exact inverse of the final permutation, and presents the result as L0/R0 halves to the round engine on a second valid/ready handshake. It double-buffers, so assembly of the next block overlaps holding of the current output.

## Interface
- No parameters; the block is fixed to the DES 64-bit block and 8-bit byte lane.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of a partially assembled block; the output register is unaffected.
- in_valid  input  1  in_byte / in_dec are valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- in_byte  input  8  next block byte, most significant byte first (byte 0 = DES bits 1..8).
- in_dec  input  1  mode sideband; sampled only with byte 0 of a block (1 = decrypt).
- out_valid  output  1  l0 / r0 / out_dec hold a permuted block.
- out_ready  input  1  round engine accepts the block this cycle.
- l0  output  32  IP result bits 63..32.
- r0  output  32  IP result bits 31..0.
- out_dec  output  1  in_dec captured with byte 0 of the delivered block.

## Operation
- Bit numbering: DES bit n (1..64) is vector bit 64-n, so bit 1 is the MSB.
- Permutation: ip[64-k] = blk[64-IP[k]] for k = 1..64, using the standard DES IP table 58 50 42 34 26 18 10 2 / 60 52 44 36 28 20 12 4 / 62 54 46 38 30 22 14 6 / 64 56 48 40 32 24 16 8 / 57 49 41 33 25 17 9 1 / 59 51 43 35 27 19 11 3 / 61 53 45 37 29 21 13 5 / 63 55 47 39 31 23 15 7.
- The permutation is a pure rewire with no arithmetic. The IP output fed through the existing final-permutation block must reproduce blk bit-for-bit.
- Assembly stage: 64-bit shift register asm, 4-bit byte count cnt (0..8), and registered dec_cap.
  - Accept condition: in_valid & in_ready. On accept, asm <= {asm[55:0], in_byte} and cnt <= cnt+1.
  - If cnt==0 on accept, dec_cap <= in_dec.
  - in_ready = (cnt < 8). It is combinational from registered cnt only and never depends on in_valid or out_ready.
- Output stage: registers l0, r0, out_dec, out_valid.
  - Transfer condition: cnt==8 & (!out_valid | out_ready). On transfer, {l0,r0} <= IP(asm), out_dec <= dec_cap, out_valid <= 1, cnt <= 0.
  - Drain without transfer: out_valid & out_ready & !(transfer condition) leads to out_valid <= 0.
  - When out_valid=1 and out_ready=0, l0/r0/out_dec are held stable.
- Simultaneous events:
  - Drain and transfer in the same cycle: the new block is loaded and out_valid stays 1, with no bubble.
  - flush with an accept in the same cycle: flush wins, the byte is dropped, cnt <= 0.
  - flush with cnt==8 and a transfer condition true: the transfer still happens (the block is complete), and cnt <= 0.
  - flush with cnt==8 and no transfer: the block is discarded and cnt <= 0.
- Reset (also mid-block, or mid-hold): cnt=0, asm=0, dec_cap=0, out_valid=0, l0=0, r0=0, out_dec=0. in_ready=1 in the first cycle after reset.

## Timing
- in_ready is high during cnt 0..7; bytes may arrive back-to-back.
- Latency: if the 8th byte is accepted at edge N, the transfer happens at edge N+1 (when the output is free), and out_valid is high after edge N+1. From the 8th byte to out_valid is 2 edges.
- in_ready is low for exactly one cycle (cnt==8) when the output is free. It stays low for as long as the output is full and out_ready=0.
- Maximum throughput is one block per 9 cycles with in_valid and out_ready held high.
- out_valid falls only on a drain without transfer.

## Test plan
- Known vector: stream 01 23 45 67 89 AB CD EF with in_dec=0 -> l0=CC00CCFF, r0=F0AAF0AA, out_dec=0, out_valid high 2 edges after the 8th accept.
- Round trip: 1000 random blocks, each IP output fed through the final-permutation block -> equals the input block. Single-bit blocks 1<<i for i = 0..63 -> exactly one output bit set, at the IP position.
- Backpressure: out_ready=0 while a second block streams in -> second-block bytes 0..7 accepted, in_ready low afterwards, first l0/r0 stable. Raise out_ready -> second block loaded in the same cycle with no out_valid bubble.
- Mode sideband: in_dec=1 on byte 0 only, then toggled on bytes 1..7 -> out_dec=1.
- Flush: flush after 3 bytes, then stream 01..EF -> output CC00CCFF/F0AAF0AA. Flush coincident with a byte accept -> that byte is dropped and cnt=0.
- Reset mid-block and while out_valid=1 -> all outputs 0, in_ready=1 the next cycle, and the next full block is permuted correctly.
